alu_cmd_sequencer: RTL and testbench
====================================

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port cmd_valid  input  1  command offered.
REQ-004 SHALL have port cmd_ready  output  1  sequencer accepts command.
REQ-005 SHALL have port cmd_op  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 ACC (repeated add), 110/111 illegal.
REQ-006 SHALL have ports cmd_a and cmd_b  input  64 each  operands.
REQ-007 SHALL have port cmd_cnt  input  4  extra ACC iterations; ignored for other ops.
REQ-008 SHALL have ports alu_a and alu_b  output  64 each  operands to the external ALU.
REQ-009 SHALL have ports alu_b_inv, alu_sel0 and alu_sel1  output  1 each  ALU controls; {alu_sel1,alu_sel0}: 00 sum, 01 AND, 10 OR, 11 XOR.
REQ-010 SHALL have port alu_out  input  64  ALU result, combinational from alu_* outputs.
REQ-011 SHALL have port alu_ov  input  1  ALU carry/borrow flag.
REQ-012 SHALL have ports rsp_valid  output  1 and rsp_ready  input  1  response handshake.
REQ-013 SHALL have ports rsp_data  output  64, rsp_ov  output  1, rsp_zero  output  1 and rsp_err  output  1  response payload.

Function
REQ-014 SHALL implement FSM states IDLE, EXEC, RESP; cmd_ready = 1 only in IDLE.
REQ-015 IDLE: cmd_valid=1 SHALL capture op/a/b/cnt into registers; legal op -> EXEC, illegal op -> RESP with rsp_err=1, rsp_data=0, rsp_ov=0, rsp_zero=1.
REQ-016 EXEC SHALL drive alu_a/alu_b from registers and decoded controls: ADD b_inv=0 sel=00; SUB b_inv=1 sel=00; AND 01; OR 10; XOR 11; ACC b_inv=0 sel=00; b_inv=0 for logic ops.
REQ-017 Each EXEC cycle SHALL register alu_out into the result register and OR alu_ov into a sticky ov flag cleared on command accept.
REQ-018 Non-ACC op: EXEC lasts exactly 1 cycle, then RESP.
REQ-019 ACC: result register feeds alu_a on each following EXEC cycle, alu_b constant; EXEC lasts cmd_cnt+1 cycles (cmd_cnt=0 -> single add; cmd_cnt=15 -> 16 adds), then RESP.
REQ-020 Latency: command accepted at edge T -> rsp_valid=1 after edge T+2+cnt (cnt=0 for non-ACC).
REQ-021 RESP: rsp_valid=1; rsp_data/rsp_ov/rsp_zero/rsp_err SHALL stay stable until rsp_ready=1 is sampled; then -> IDLE.
REQ-022 rsp_zero SHALL equal (rsp_data == 0); arithmetic wraps modulo 2^64, no saturation.
REQ-023 rsp_ready=1 while not in RESP SHALL have no effect; cmd_valid while cmd_ready=0 SHALL be ignored (not queued).
REQ-024 Outside EXEC, alu_b_inv, alu_sel0, alu_sel1 SHALL be 0; alu_a/alu_b hold last registered values.

Reset
REQ-025 rst=1 at a rising edge SHALL force IDLE from any state, aborting any command or pending response.
REQ-026 After reset: cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_ov=0, rsp_zero=0, rsp_err=0, alu_a=0, alu_b=0, alu_b_inv=0, alu_sel0=0, alu_sel1=0.

Verification
REQ-027 ADD a=5,b=7 -> rsp_valid 2 cycles after accept, rsp_data=12, ov=0, zero=0; SUB a=7,b=7 -> data=0, zero=1, ov=1 (no borrow).
REQ-028 ADD a=FFFF_FFFF_FFFF_FFFF,b=1 -> data=0, zero=1, ov=1; XOR a=F0F0..,b=FF00.. -> data=0FF0..; during EXEC sel=11, b_inv=0.
REQ-029 ACC a=1,b=3,cnt=4 -> 5 EXEC cycles, data=16, rsp_valid at T+6.
REQ-030 Response backpressure: rsp_ready=0 for 5 cycles -> payload stable, cmd_ready=0, new cmd_valid ignored; rsp_ready=1 -> IDLE next edge.
REQ-031 Illegal op 111 -> rsp_err=1, data=0 at T+1; rst asserted mid-ACC (cnt=15, 3rd cycle) -> next cycle all outputs at reset values, cmd_ready=1.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
// Accepts one ALU command at a time and steps it through an external
// combinational ALU. It returns a single response, which is held until the
// consumer takes it.
//
// Ports
//   clk, rst            : clock and synchronous active-high reset
//   cmd_valid/cmd_ready : command handshake (ready only while idle)
//   cmd_op              : 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR,
//                         101 ACC (repeated add), 110/111 illegal
//   cmd_a, cmd_b        : 64-bit operands
//   cmd_cnt             : extra ACC iterations (ACC runs cmd_cnt+1 adds)
//   alu_a, alu_b        : operands presented to the external ALU
//   alu_b_inv           : invert B with carry-in (subtract)
//   alu_sel1/alu_sel0   : 00 sum, 01 AND, 10 OR, 11 XOR
//   alu_out, alu_ov     : ALU result and carry/borrow flag
//   rsp_valid/rsp_ready : response handshake
//   rsp_data/ov/zero/err: response payload, stable while rsp_valid is high
module alu_cmd_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [63:0] cmd_a,
  input  logic [63:0] cmd_b,
  input  logic [3:0]  cmd_cnt,
  output logic [63:0] alu_a,
  output logic [63:0] alu_b,
  output logic        alu_b_inv,
  output logic        alu_sel0,
  output logic        alu_sel1,
  input  logic [63:0] alu_out,
  input  logic        alu_ov,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_data,
  output logic        rsp_ov,
  output logic        rsp_zero,
  output logic        rsp_err
);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpOr  = 3'b011;
  localparam logic [2:0] OpXor = 3'b100;
  localparam logic [2:0] OpAcc = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] alu_a_q, alu_a_d;
  logic [63:0] alu_b_q, alu_b_d;
  logic [63:0] result_q, result_d;
  logic        ov_q, ov_d;
  logic        zero_q, zero_d;
  logic        err_q, err_d;
  logic        opLegal;

  assign opLegal = (cmd_op <= OpAcc);

  // The operand registers drive the ALU directly, so the ALU inputs hold their
  // last values whenever no command is executing. The payload registers are
  // only written in IDLE (accept) and EXEC, so they cannot move while a
  // response waits for rsp_ready.
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign rsp_data  = result_q;
  assign rsp_ov    = ov_q;
  assign rsp_zero  = zero_q;
  assign rsp_err   = err_q;

  // State and datapath registers. Reset returns everything to zero and IDLE.
  // This abandons any command in flight and any response still pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      cnt_q    <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      result_q <= '0;
      ov_q     <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      result_q <= result_d;
      ov_q     <= ov_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic and ALU control decode.
  // In IDLE, an accepted command loads the operands. An illegal op skips
  // EXEC and produces an error response immediately.
  // Each EXEC cycle captures the ALU result and ORs alu_ov into the sticky
  // flag. For ACC, the result is also fed back into alu_a while iterations
  // remain; cnt_q counts the adds still outstanding after the current one.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    result_d  = result_q;
    ov_d      = ov_q;
    zero_d    = zero_q;
    err_d     = err_q;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    alu_b_inv = 1'b0;
    alu_sel0  = 1'b0;
    alu_sel1  = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d  = cmd_op;
          cnt_d = cmd_cnt;
          ov_d  = 1'b0;
          if (opLegal) begin
            alu_a_d = cmd_a;
            alu_b_d = cmd_b;
            err_d   = 1'b0;
            state_d = EXEC;
          end else begin
            result_d = '0;
            zero_d   = 1'b1;
            err_d    = 1'b1;
            state_d  = RESP;
          end
        end
      end

      EXEC: begin
        case (op_q)
          OpSub:   alu_b_inv = 1'b1;
          OpAnd:   alu_sel0  = 1'b1;
          OpOr:    alu_sel1  = 1'b1;
          OpXor: begin
            alu_sel0 = 1'b1;
            alu_sel1 = 1'b1;
          end
          default: begin
          end
        endcase

        result_d = alu_out;
        ov_d     = ov_q | alu_ov;
        zero_d   = (alu_out == 64'd0);

        if ((op_q == OpAcc) && (cnt_q != 4'd0)) begin
          cnt_d   = cnt_q - 4'd1;
          alu_a_d = alu_out;
        end else begin
          state_d = RESP;
        end
      end

      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // OpAdd is listed only for completeness; it decodes to the default controls.
  logic unusedOpAdd;
  assign unusedOpAdd = (op_q == OpAdd);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer
// Directed bench for alu_cmd_sequencer. It provides a behavioural model of the
// external combinational ALU and drives hand-computed command vectors. It then
// checks the response payload, the latency and the ALU control decode.
module tb_alu_cmd_sequencer;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [63:0] cmd_a;
  logic [63:0] cmd_b;
  logic [3:0]  cmd_cnt;
  logic [63:0] alu_a;
  logic [63:0] alu_b;
  logic        alu_b_inv;
  logic        alu_sel0;
  logic        alu_sel1;
  logic [63:0] alu_out;
  logic        alu_ov;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic        rsp_ov;
  logic        rsp_zero;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;
  int lat;

  alu_cmd_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_cnt   (cmd_cnt),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_b_inv (alu_b_inv),
    .alu_sel0  (alu_sel0),
    .alu_sel1  (alu_sel1),
    .alu_out   (alu_out),
    .alu_ov    (alu_ov),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_ov    (rsp_ov),
    .rsp_zero  (rsp_zero),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU model: the sum path adds B (or ~B with carry-in 1) and
  // reports the carry out; logic ops never flag overflow.
  logic [63:0] bEff;
  logic [64:0] sumFull;
  always_comb begin
    bEff    = alu_b_inv ? ~alu_b : alu_b;
    sumFull = {1'b0, alu_a} + {1'b0, bEff} + {64'd0, alu_b_inv};
    alu_ov  = 1'b0;
    case ({alu_sel1, alu_sel0})
      2'b00: begin
        alu_out = sumFull[63:0];
        alu_ov  = sumFull[64];
      end
      2'b01:   alu_out = alu_a & alu_b;
      2'b10:   alu_out = alu_a | alu_b;
      default: alu_out = alu_a ^ alu_b;
    endcase
  end

  // Advance one clock; sampling happens 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare a 64-bit value against its expected value and record the outcome.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare a single bit against its expected value.
  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Offer one command while idle and clock it in. On return the accept edge
  // has passed and the sequencer holds the command.
  task automatic applyStimulus(input logic [2:0] op, input logic [63:0] a,
                               input logic [63:0] b, input logic [3:0] cnt);
    checkBit("cmd_ready_before_accept", cmd_ready, 1'b1);
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_cnt   = cnt;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Count edges from command offer to rsp_valid. The accept edge counts as 1.
  // The wait is bounded so that a stuck DUT still reaches the summary line.
  task automatic waitResp(input string tag, input int expLat);
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    checkOutput(tag, 64'(lat), 64'(expLat));
  endtask

  // Check the response payload.
  task automatic checkResp(input string tag, input logic [63:0] data,
                           input logic ov, input logic zero, input logic err);
    checkOutput({tag, "_data"}, rsp_data, data);
    checkBit({tag, "_ov"}, rsp_ov, ov);
    checkBit({tag, "_zero"}, rsp_zero, zero);
    checkBit({tag, "_err"}, rsp_err, err);
  endtask

  // Take the response and confirm the return to IDLE.
  task automatic takeResp(input string tag);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkBit({tag, "_idle_ready"}, cmd_ready, 1'b1);
    checkBit({tag, "_idle_valid"}, rsp_valid, 1'b0);
  endtask

  // Directed test sequence.
  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 3'b000;
    cmd_a     = '0;
    cmd_b     = '0;
    cmd_cnt   = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    checkBit("rst_cmd_ready", cmd_ready, 1'b1);
    checkBit("rst_rsp_valid", rsp_valid, 1'b0);
    checkOutput("rst_rsp_data", rsp_data, 64'd0);
    checkBit("rst_rsp_ov", rsp_ov, 1'b0);
    checkBit("rst_rsp_zero", rsp_zero, 1'b0);
    checkBit("rst_rsp_err", rsp_err, 1'b0);
    checkOutput("rst_alu_a", alu_a, 64'd0);
    checkOutput("rst_alu_b", alu_b, 64'd0);
    checkOutput("rst_alu_ctrl", {61'd0, alu_b_inv, alu_sel1, alu_sel0}, 64'd0);

    // Asserting rsp_ready while idle must have no effect.
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkBit("idle_rsp_ready_noeffect", cmd_ready, 1'b1);

    // ADD 5+7.
    applyStimulus(3'b000, 64'd5, 64'd7, 4'd0);
    checkOutput("add_exec_alu_a", alu_a, 64'd5);
    checkOutput("add_exec_alu_b", alu_b, 64'd7);
    checkOutput("add_exec_ctrl", {61'd0, alu_b_inv, alu_sel1, alu_sel0}, 64'd0);
    checkBit("add_exec_cmd_ready", cmd_ready, 1'b0);
    checkBit("add_exec_rsp_valid", rsp_valid, 1'b0);
    waitResp("add_latency", 2);
    checkResp("add", 64'd12, 1'b0, 1'b0, 1'b0);
    takeResp("add");

    // SUB 7-7: the result is zero, and the carry is set because no borrow occurs.
    applyStimulus(3'b001, 64'd7, 64'd7, 4'd0);
    checkOutput("sub_exec_ctrl", {61'd0, alu_b_inv, alu_sel1, alu_sel0}, 64'd4);
    waitResp("sub_latency", 2);
    checkResp("sub", 64'd0, 1'b1, 1'b1, 1'b0);
    takeResp("sub");

    // ADD with wraparound.
    applyStimulus(3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd0);
    waitResp("addwrap_latency", 2);
    checkResp("addwrap", 64'd0, 1'b1, 1'b1, 1'b0);
    takeResp("addwrap");

    // XOR.
    applyStimulus(3'b100, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 4'd0);
    checkOutput("xor_exec_ctrl", {61'd0, alu_b_inv, alu_sel1, alu_sel0}, 64'd3);
    waitResp("xor_latency", 2);
    checkResp("xor", 64'h0FF0_0FF0_0FF0_0FF0, 1'b0, 1'b0, 1'b0);
    takeResp("xor");

    // AND and OR.
    applyStimulus(3'b010, 64'h0000_00FF_0000_FFFF, 64'h0000_0F0F_0000_00F0, 4'd0);
    checkOutput("and_exec_ctrl", {61'd0, alu_b_inv, alu_sel1, alu_sel0}, 64'd1);
    waitResp("and_latency", 2);
    checkResp("and", 64'h0000_000F_0000_00F0, 1'b0, 1'b0, 1'b0);
    takeResp("and");

    applyStimulus(3'b011, 64'h1200_0000_0000_0034, 64'h0056_0000_0000_7800, 4'd0);
    checkOutput("or_exec_ctrl", {61'd0, alu_b_inv, alu_sel1, alu_sel0}, 64'd2);
    waitResp("or_latency", 2);
    checkResp("or", 64'h1256_0000_0000_7834, 1'b0, 1'b0, 1'b0);
    takeResp("or");

    // ACC a=1 b=3 cnt=4: five adds give 16, and rsp_valid appears 6 edges after the offer.
    applyStimulus(3'b101, 64'd1, 64'd3, 4'd4);
    checkOutput("acc_exec_ctrl", {61'd0, alu_b_inv, alu_sel1, alu_sel0}, 64'd0);
    waitResp("acc4_latency", 6);
    checkResp("acc4", 64'd16, 1'b0, 1'b0, 1'b0);
    takeResp("acc4");

    // ACC cnt=0 is a single add.
    applyStimulus(3'b101, 64'd10, 64'd3, 4'd0);
    waitResp("acc0_latency", 2);
    checkResp("acc0", 64'd13, 1'b0, 1'b0, 1'b0);
    takeResp("acc0");

    // ACC cnt=15 runs 16 adds: 5 + 16*2 = 37.
    applyStimulus(3'b101, 64'd5, 64'd2, 4'd15);
    waitResp("acc15_latency", 17);
    checkResp("acc15", 64'd37, 1'b0, 1'b0, 1'b0);
    takeResp("acc15");

    // Sticky overflow: the first add wraps to 0 with a carry, and the second gives 1.
    applyStimulus(3'b101, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd1);
    waitResp("accwrap_latency", 3);
    checkResp("accwrap", 64'd1, 1'b1, 1'b0, 1'b0);
    takeResp("accwrap");

    // The overflow flag clears on the next accept. Then hold the response under
    // backpressure while offering a command that must be ignored.
    applyStimulus(3'b000, 64'd10, 64'd20, 4'd0);
    waitResp("bp_latency", 2);
    cmd_op    = 3'b100;
    cmd_a     = 64'hDEAD;
    cmd_b     = 64'hBEEF;
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkBit("bp_rsp_valid", rsp_valid, 1'b1);
      checkBit("bp_cmd_ready", cmd_ready, 1'b0);
      checkResp("bp_hold", 64'd30, 1'b0, 1'b0, 1'b0);
    end
    cmd_valid = 1'b0;
    takeResp("bp");
    tick();
    checkBit("bp_not_queued_valid", rsp_valid, 1'b0);
    checkOutput("bp_not_queued_ctrl", {61'd0, alu_b_inv, alu_sel1, alu_sel0}, 64'd0);
    checkOutput("bp_alu_a_held", alu_a, 64'd10);

    // Illegal op: an error response appears right after the accept edge.
    applyStimulus(3'b111, 64'd9, 64'd9, 4'd0);
    checkBit("illegal_rsp_valid", rsp_valid, 1'b1);
    checkResp("illegal", 64'd0, 1'b0, 1'b1, 1'b1);
    takeResp("illegal");

    // Reset during the third EXEC cycle of a long ACC.
    applyStimulus(3'b101, 64'd1, 64'd1, 4'd15);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkBit("midrst_cmd_ready", cmd_ready, 1'b1);
    checkBit("midrst_rsp_valid", rsp_valid, 1'b0);
    checkResp("midrst", 64'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("midrst_alu_a", alu_a, 64'd0);
    checkOutput("midrst_alu_b", alu_b, 64'd0);
    checkOutput("midrst_ctrl", {61'd0, alu_b_inv, alu_sel1, alu_sel0}, 64'd0);
    tick();
    checkBit("midrst_stays_idle", rsp_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
